node_port_arbiter: RTL

- Shares one router core's node-side load interface (Packet_From_Node / Packet_From_Node_Valid / Core_Load_Ack) among N local requesters, such as processor ports or DMA.
- Arbitration is round-robin. The granted packet is captured into a holding register and offered to the core until it is acknowledged.
- Timeout and self-addressed drop are handled here, so a stalled or misaddressed requester cannot lock the ring interface.
- Sits between the node-side requesters and router_core on Clk_R.

---
 rtl/node_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/node_port_arbiter.sv
// node_port_arbiter: round-robin sharing of the router core's node load port.
// The winning packet is latched into a holding register and offered until the
// core acks it or the ack timeout expires; self-addressed packets are dropped
// without ever being offered. Sent_Pulse, Err_Pulse and Err_Code are registered,
// so they appear together in the GAP cycle after the handoff, timeout or drop.
module node_port_arbiter #(
    parameter int N_REQ       = 4,
    parameter int PKT_W       = 29,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                     Clk_R,
    input  logic                     Rst,
    input  logic [3:0]               r_addr,
    input  logic [N_REQ-1:0]         Req_Valid,
    input  logic [N_REQ*PKT_W-1:0]   Req_Packet,
    output logic [N_REQ-1:0]         Req_Ready,
    output logic [PKT_W-1:0]         Packet_From_Node,
    output logic                     Packet_From_Node_Valid,
    input  logic                     Core_Load_Ack,
    output logic [2:0]               Grant_Id,
    output logic                     Busy,
    output logic                     Sent_Pulse,
    output logic                     Err_Pulse,
    output logic [1:0]               Err_Code
);
    localparam int          IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR      = N_REQ;
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_OFFER,
        S_DROP,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PKT_W-1:0]  hold_q, hold_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              sent_q, sent_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              found;
    logic [2:0]        sel;
    logic [PKT_W-1:0]  sel_pkt;
    int unsigned       idx;

    // Round-robin search: first valid requester after last_q, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (!found && Req_Valid[idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = 3'(idx);
            end
        end
    end

    // Packet presented by the selected requester.
    always_comb begin
        sel_pkt = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (3'(j) == sel) begin
                sel_pkt = Req_Packet[j*PKT_W +: PKT_W];
            end
        end
    end

    // Next-state logic and holding-register / counter / status updates.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sent_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (|Req_Valid) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (found) begin
                    hold_d  = sel_pkt;
                    grant_d = sel;
                    last_d  = sel;
                    state_d = (sel_pkt[PKT_W-1 -: 4] == r_addr) ? S_DROP : S_OFFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (Core_Load_Ack) begin
                    sent_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DROP: begin
                err_d   = 1'b1;
                code_d  = 2'b10;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = (|Req_Valid) ? S_ARB : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, holding register, pointer, counter and status registers.
    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            grant_q <= '0;
            last_q  <= 3'(N_REQ - 1);
            cnt_q   <= '0;
            sent_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign Req_Ready              = (state_q == S_ARB && found) ? (N_REQ'(1) << sel) : '0;
    assign Packet_From_Node       = hold_q;
    assign Packet_From_Node_Valid = (state_q == S_OFFER);
    assign Grant_Id               = grant_q;
    assign Busy                   = (state_q != S_IDLE);
    assign Sent_Pulse             = sent_q;
    assign Err_Pulse              = err_q;
    assign Err_Code               = code_q;

endmodule
